mem_req_arbiter: RTL and testbench

- Parametrised N-channel arbiter for the sram-like request interface (req/addr_ok/data_ok) used by the pipeline once it moves off the single-cycle SRAM ports.
- Merges the IF, EXE and later channels onto one downstream sram-like port.
- Tracks in-flight transactions in an ID FIFO so each data_ok/rdata is routed back to the issuing channel.
- Sits between the pipeline stages and the AXI bridge or memory.

---
 rtl/mem_req_arbiter_if.sv | 43 ++++
 rtl/mem_req_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// Bundle of the N upstream sram-like request channels and the single downstream
// sram-like port seen by mem_req_arbiter.
interface mem_req_arbiter_if #(
    parameter int N_CH = 2,
    parameter int DW   = 32,
    parameter int AW   = 32
);
    logic [N_CH-1:0]        s_req;
    logic [N_CH-1:0]        s_wr;
    logic [2*N_CH-1:0]      s_size;
    logic [N_CH*DW/8-1:0]   s_wstrb;
    logic [N_CH*AW-1:0]     s_addr;
    logic [N_CH*DW-1:0]     s_wdata;
    logic [N_CH-1:0]        s_addr_ok;
    logic [N_CH-1:0]        s_data_ok;
    logic [DW-1:0]          s_rdata;

    logic                   m_req;
    logic                   m_wr;
    logic [1:0]             m_size;
    logic [DW/8-1:0]        m_wstrb;
    logic [AW-1:0]          m_addr;
    logic [DW-1:0]          m_wdata;
    logic                   m_addr_ok;
    logic                   m_data_ok;
    logic [DW-1:0]          m_rdata;

    // Arbiter side: consumes upstream requests, drives the downstream port.
    modport slave (
        input  s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata,
        output s_addr_ok, s_data_ok, s_rdata,
        output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        input  m_addr_ok, m_data_ok, m_rdata
    );

    // Environment side: pipeline requesters plus downstream memory/bridge.
    modport master (
        output s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata,
        input  s_addr_ok, s_data_ok, s_rdata,
        input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        output m_addr_ok, m_data_ok, m_rdata
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// N-channel sram-like request arbiter with in-order response routing via an ID FIFO.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (highest channel wins) instead of round-robin.
module mem_req_arbiter #(
    parameter int N_CH    = 2,
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    mem_req_arbiter_if.slave             bus,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         resp_err
);
    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int SW = DW / 8;

    logic [IW-1:0] id_mem [MAX_OUT];
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          lock_reg, lock_next;
    logic [IW-1:0] lock_ch_reg, lock_ch_next;
    logic          resp_err_reg, resp_err_next;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [IW-1:0] rr_reg, rr_next;
`endif

    logic [IW-1:0] grant;
    logic [IW-1:0] head;
    logic          eligible;
    logic          m_req_int;
    logic          push;
    logic          pop;

    // Grant selection; an outstanding stalled request always keeps the port.
    always_comb begin
        grant = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N_CH; i++) begin
            if (bus.s_req[i]) begin
                grant = IW'(i);
            end
        end
`else
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (bus.s_req[(int'(rr_reg) + k) % N_CH]) begin
                grant = IW'((int'(rr_reg) + k) % N_CH);
            end
        end
`endif
        if (lock_reg) begin
            grant = lock_ch_reg;
        end
    end

    assign eligible  = (count_reg < CW'(MAX_OUT)) || lock_reg;
    assign m_req_int = eligible && bus.s_req[grant];
    assign push      = m_req_int && bus.m_addr_ok;
    assign pop       = bus.m_data_ok && (count_reg != '0);
    assign head      = id_mem[rd_ptr_reg];

    always_comb begin
        bus.m_req   = m_req_int;
        bus.m_wr    = bus.s_wr[grant];
        bus.m_size  = bus.s_size[int'(grant)*2 +: 2];
        bus.m_wstrb = '0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        if (m_req_int) begin
            bus.m_wstrb = bus.s_wstrb[int'(grant)*SW +: SW];
            bus.m_addr  = bus.s_addr[int'(grant)*AW +: AW];
            bus.m_wdata = bus.s_wdata[int'(grant)*DW +: DW];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign bus.s_addr_ok[gi] = push && (grant == IW'(gi));
            assign bus.s_data_ok[gi] = pop && (head == IW'(gi));
        end
    endgenerate

    assign bus.s_rdata = bus.m_rdata;
    assign outstanding = count_reg;
    assign resp_err    = resp_err_reg;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        lock_next     = lock_reg;
        lock_ch_next  = lock_ch_reg;
        resp_err_next = resp_err_reg;
`ifndef MEM_ARB_FIXED_PRIO_EN
        rr_next       = rr_reg;
`endif
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
            lock_next   = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_next     = (int'(grant) == N_CH - 1) ? '0 : grant + 1'b1;
`endif
        end else if (m_req_int) begin
            lock_next    = 1'b1;
            lock_ch_next = grant;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
        // A response with nothing in flight cannot be routed anywhere.
        if (bus.m_data_ok && (count_reg == '0)) begin
            resp_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            lock_reg     <= 1'b0;
            lock_ch_reg  <= '0;
            resp_err_reg <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_reg       <= '0;
`endif
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            lock_reg     <= lock_next;
            lock_ch_reg  <= lock_ch_next;
            resp_err_reg <= resp_err_next;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_reg       <= rr_next;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr_reg] <= grant;
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter (N_CH=2, DW=32, AW=32, MAX_OUT=4).
module tb_mem_req_arbiter;
    logic       clk;
    logic       reset;
    logic [2:0] outstanding;
    logic       resp_err;
    int         pass_cnt;
    int         total_cnt;

    mem_req_arbiter_if #(.N_CH(2), .DW(32), .AW(32)) bus ();

    mem_req_arbiter #(.N_CH(2), .DW(32), .AW(32), .MAX_OUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .outstanding(outstanding),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && bus.m_req && bus.m_addr_ok)
            $display("txn req  grant=%b addr=%h", bus.s_addr_ok, bus.m_addr);
        if (!reset && bus.m_data_ok)
            $display("txn resp route=%b rdata=%h", bus.s_data_ok, bus.s_rdata);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                          input logic aok, input logic dok, input logic [31:0] rdata);
        @(negedge clk);
        bus.s_req     = req;
        bus.s_addr    = {a1, a0};
        bus.m_addr_ok = aok;
        bus.m_data_ok = dok;
        bus.m_rdata   = rdata;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        bus.s_req     = 2'b00;
        bus.m_addr_ok = 1'b0;
        bus.m_data_ok = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            set_in(2'b00, 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0, 32'h0);
            total_cnt++;
            if (bus.m_req !== 1'b0) $display("FAIL reset_m_req: got %b want 0", bus.m_req);
            else pass_cnt++;
            total_cnt++;
            if (outstanding !== 3'd0) $display("FAIL reset_outstanding: got %0d want 0", outstanding);
            else pass_cnt++;
            total_cnt++;
            if (resp_err !== 1'b0) $display("FAIL reset_resp_err: got %b want 0", resp_err);
            else pass_cnt++;
            total_cnt++;
            if (bus.s_addr_ok !== 2'b00 || bus.s_data_ok !== 2'b00)
                $display("FAIL reset_s_ok: got addr_ok=%b data_ok=%b want 00/00", bus.s_addr_ok, bus.s_data_ok);
            else pass_cnt++;
            total_cnt++;
            if (bus.m_addr !== 32'h0 || bus.m_wdata !== 32'h0 || bus.m_wstrb !== 4'h0)
                $display("FAIL idle_payload_zero: got addr=%h wdata=%h wstrb=%h want 0", bus.m_addr, bus.m_wdata, bus.m_wstrb);
            else pass_cnt++;
        end
    endtask

    task automatic test_arbitration();
        int         exp_ch;
        int         prev_ch;
        logic [1:0] exp_mask;
        logic [31:0] exp_addr;
        do_reset();
        prev_ch = 0;
        for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_ch = 1;
`else
            exp_ch = k % 2;
`endif
            exp_mask = 2'b01 << exp_ch;
            exp_addr = (exp_ch == 1) ? 32'h0000_0200 : 32'h0000_0100;
            set_in(2'b11, 32'h0000_0100, 32'h0000_0200, 1'b1, (k > 0), 32'h1000 + k - 1);
            total_cnt++;
            if (bus.m_req !== 1'b1 || bus.s_addr_ok !== exp_mask)
                $display("FAIL arb_grant_%0d: got m_req=%b addr_ok=%b want 1/%b", k, bus.m_req, bus.s_addr_ok, exp_mask);
            else pass_cnt++;
            total_cnt++;
            if (bus.m_addr !== exp_addr) $display("FAIL arb_addr_%0d: got %h want %h", k, bus.m_addr, exp_addr);
            else pass_cnt++;
            if (k > 0) begin
                total_cnt++;
                if (bus.s_data_ok !== (2'b01 << prev_ch) || bus.s_rdata !== 32'h1000 + k - 1)
                    $display("FAIL arb_resp_%0d: got data_ok=%b rdata=%h want %b/%h", k, bus.s_data_ok,
                             bus.s_rdata, 2'b01 << prev_ch, 32'h1000 + k - 1);
                else pass_cnt++;
                total_cnt++;
                if (outstanding !== 3'd1) $display("FAIL arb_outstanding_%0d: got %0d want 1", k, outstanding);
                else pass_cnt++;
            end
            prev_ch = exp_ch;
        end
        set_in(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1005);
        total_cnt++;
        if (bus.s_data_ok !== (2'b01 << prev_ch) || bus.s_rdata !== 32'h1005)
            $display("FAIL arb_resp_last: got data_ok=%b rdata=%h want %b/00001005", bus.s_data_ok, bus.s_rdata, 2'b01 << prev_ch);
        else pass_cnt++;
        set_in(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        total_cnt++;
        if (outstanding !== 3'd0) $display("FAIL arb_drained: got %0d want 0", outstanding);
        else pass_cnt++;
    endtask

    task automatic test_lock();
        do_reset();
        set_in(2'b01, 32'h0000_0100, 32'h2000_0000, 1'b1, 1'b0, 32'h0);
        total_cnt++;
        if (bus.s_addr_ok !== 2'b01) $display("FAIL lock_pre_accept: got %b want 01", bus.s_addr_ok);
        else pass_cnt++;
        set_in(2'b01, 32'h1C00_0000, 32'h2000_0000, 1'b0, 1'b1, 32'h77);
        total_cnt++;
        if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h1C00_0000 || bus.s_addr_ok !== 2'b00)
            $display("FAIL lock_stall0: got m_req=%b addr=%h addr_ok=%b want 1/1c000000/00", bus.m_req, bus.m_addr, bus.s_addr_ok);
        else pass_cnt++;
        total_cnt++;
        if (bus.s_data_ok !== 2'b01) $display("FAIL lock_resp: got %b want 01", bus.s_data_ok);
        else pass_cnt++;
        for (int c = 1; c < 3; c++) begin
            set_in(2'b11, 32'h1C00_0000, 32'h2000_0000, 1'b0, 1'b0, 32'h0);
            total_cnt++;
            if (bus.m_addr !== 32'h1C00_0000 || bus.s_addr_ok !== 2'b00)
                $display("FAIL lock_stall%0d: got addr=%h addr_ok=%b want 1c000000/00", c, bus.m_addr, bus.s_addr_ok);
            else pass_cnt++;
        end
        set_in(2'b11, 32'h1C00_0000, 32'h2000_0000, 1'b1, 1'b0, 32'h0);
        total_cnt++;
        if (bus.m_addr !== 32'h1C00_0000 || bus.s_addr_ok !== 2'b01)
            $display("FAIL lock_accept: got addr=%h addr_ok=%b want 1c000000/01", bus.m_addr, bus.s_addr_ok);
        else pass_cnt++;
        set_in(2'b10, 32'h1C00_0000, 32'h2000_0000, 1'b1, 1'b0, 32'h0);
        total_cnt++;
        if (bus.m_addr !== 32'h2000_0000 || bus.s_addr_ok !== 2'b10)
            $display("FAIL lock_next_ch1: got addr=%h addr_ok=%b want 20000000/10", bus.m_addr, bus.s_addr_ok);
        else pass_cnt++;
    endtask

    task automatic test_full();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_in(2'b01, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 32'h0);
            total_cnt++;
            if (bus.s_addr_ok !== 2'b01) $display("FAIL full_fill%0d: got %b want 01", c, bus.s_addr_ok);
            else pass_cnt++;
        end
        set_in(2'b01, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 32'h0);
        total_cnt++;
        if (outstanding !== 3'd4 || bus.m_req !== 1'b0 || bus.s_addr_ok !== 2'b00)
            $display("FAIL full_block: got out=%0d m_req=%b addr_ok=%b want 4/0/00", outstanding, bus.m_req, bus.s_addr_ok);
        else pass_cnt++;
        set_in(2'b01, 32'h0000_0100, 32'h0, 1'b1, 1'b1, 32'hBEEF);
        total_cnt++;
        if (bus.m_req !== 1'b0 || bus.s_data_ok !== 2'b01 || bus.s_rdata !== 32'hBEEF)
            $display("FAIL full_no_bypass: got m_req=%b data_ok=%b rdata=%h want 0/01/0000beef", bus.m_req, bus.s_data_ok, bus.s_rdata);
        else pass_cnt++;
        set_in(2'b01, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 32'h0);
        total_cnt++;
        if (outstanding !== 3'd3 || bus.m_req !== 1'b1 || bus.s_addr_ok !== 2'b01)
            $display("FAIL full_reopen: got out=%0d m_req=%b addr_ok=%b want 3/1/01", outstanding, bus.m_req, bus.s_addr_ok);
        else pass_cnt++;
        for (int c = 0; c < 4; c++) begin
            set_in(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
            total_cnt++;
            if (bus.s_data_ok !== 2'b01) $display("FAIL full_drain%0d: got %b want 01", c, bus.s_data_ok);
            else pass_cnt++;
        end
        set_in(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        total_cnt++;
        if (outstanding !== 3'd0) $display("FAIL full_empty: got %0d want 0", outstanding);
        else pass_cnt++;
    endtask

    task automatic test_resp_err();
        do_reset();
        set_in(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h55);
        total_cnt++;
        if (bus.s_data_ok !== 2'b00 || resp_err !== 1'b0)
            $display("FAIL err_pulse: got data_ok=%b resp_err=%b want 00/0", bus.s_data_ok, resp_err);
        else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            set_in(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
            total_cnt++;
            if (resp_err !== 1'b1 || outstanding !== 3'd0)
                $display("FAIL err_sticky%0d: got resp_err=%b out=%0d want 1/0", c, resp_err, outstanding);
            else pass_cnt++;
        end
        do_reset();
        set_in(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        total_cnt++;
        if (resp_err !== 1'b0) $display("FAIL err_cleared: got %b want 0", resp_err);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_in(2'b01, 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0, 32'h0);
        set_in(2'b10, 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0, 32'h0);
        total_cnt++;
        if (bus.s_addr_ok !== 2'b10) $display("FAIL b2b_push1: got %b want 10", bus.s_addr_ok);
        else pass_cnt++;
        set_in(2'b01, 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b1, 32'hA0);
        total_cnt++;
        if (bus.s_addr_ok !== 2'b01 || bus.s_data_ok !== 2'b01 || outstanding !== 3'd2)
            $display("FAIL b2b_pushpop: got addr_ok=%b data_ok=%b out=%0d want 01/01/2", bus.s_addr_ok, bus.s_data_ok, outstanding);
        else pass_cnt++;
        set_in(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA1);
        total_cnt++;
        if (outstanding !== 3'd2 || bus.s_data_ok !== 2'b10 || bus.s_rdata !== 32'hA1)
            $display("FAIL b2b_order1: got out=%0d data_ok=%b rdata=%h want 2/10/000000a1", outstanding, bus.s_data_ok, bus.s_rdata);
        else pass_cnt++;
        set_in(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA2);
        total_cnt++;
        if (outstanding !== 3'd1 || bus.s_data_ok !== 2'b01)
            $display("FAIL b2b_order2: got out=%0d data_ok=%b want 1/01", outstanding, bus.s_data_ok);
        else pass_cnt++;
        set_in(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        total_cnt++;
        if (outstanding !== 3'd0) $display("FAIL b2b_empty: got %0d want 0", outstanding);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        reset         = 1'b1;
        bus.s_req     = 2'b00;
        bus.s_wr      = 2'b00;
        bus.s_size    = 4'b1010;
        bus.s_wstrb   = 8'hFF;
        bus.s_addr    = '0;
        bus.s_wdata   = {32'h2222_2222, 32'h1111_1111};
        bus.m_addr_ok = 1'b0;
        bus.m_data_ok = 1'b0;
        bus.m_rdata   = '0;
        test_reset();
        test_arbitration();
        test_lock();
        test_full();
        test_resp_err();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
